// File: rtl/uart_echo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_echo_pkg
// Purpose  : Shared types and constants for the UART echo engine: FSM state
//            encoding, mode bit positions, ASCII constants, uppercase helper.
// Revision : 1.0 - initial release
// ============================================================================
package uart_echo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_SEND   = 2'd2,
    ST_REPLAY = 2'd3
  } state_t;

  localparam int MODE_UPPER = 0;
  localparam int MODE_LINE  = 1;

  localparam logic [7:0] ASCII_LC_A     = 8'h61;
  localparam logic [7:0] ASCII_LC_Z     = 8'h7A;
  localparam logic [7:0] ASCII_CASE_OFS = 8'h20;
  localparam logic [7:0] ASCII_CR       = 8'h0D;

  // Lowercase ASCII letters map to uppercase; everything else is untouched.
  function automatic logic [7:0] to_upper(input logic [7:0] c);
    if (c >= ASCII_LC_A && c <= ASCII_LC_Z) begin
      return c - ASCII_CASE_OFS;
    end
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_echo_engine_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_echo_engine_if
// Purpose  : Bundles the UART RX FIFO read port and TX FIFO write port seen
//            by the echo engine. master = engine side, slave = UART side.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_echo_engine_if #(
  parameter int DBIT = 8
);
  logic            rx_empty;
  logic [DBIT-1:0] r_data;
  logic            rd_uart;
  logic            tx_full;
  logic [DBIT-1:0] w_data;
  logic            wr_uart;

  modport master (
    input  rx_empty, r_data, tx_full,
    output rd_uart, w_data, wr_uart
  );

  modport slave (
    output rx_empty, r_data, tx_full,
    input  rd_uart, w_data, wr_uart
  );
endinterface
`default_nettype wire

// File: rtl/uart_line_buf.sv
`default_nettype none
// ============================================================================
// Module   : uart_line_buf
// Purpose  : DEPTH x DBIT line storage, synchronous write, combinational read.
//            Storage is not reset; validity is tracked by the engine's count.
// Revision : 1.0 - initial release
// ============================================================================
module uart_line_buf #(
  parameter  int DBIT  = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [DBIT-1:0] wdata,
  input  logic [AW-1:0]   raddr,
  output logic [DBIT-1:0] rdata
);

  logic [DBIT-1:0] mem [DEPTH];

  // Write port: one character per enabled cycle
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule
`default_nettype wire

// File: rtl/uart_echo_engine.sv
`default_nettype none
// ============================================================================
// Module   : uart_echo_engine
// Purpose  : Echo controller between UART RX FIFO and TX FIFO with optional
//            uppercase conversion and line-buffered replay on end-of-line.
// Revision : 1.0 - initial release
// ============================================================================
module uart_echo_engine
  import uart_echo_pkg::*;
#(
  parameter int              DBIT  = 8,
  parameter int              DEPTH = 16,
  parameter logic [DBIT-1:0] EOL   = DBIT'(ASCII_CR),
  parameter int              CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  uart_echo_engine_if.master bus,
  output logic              busy,
  output logic [CNT_W-1:0]  drop_cnt
);

  localparam int            AW      = $clog2(DEPTH);
  localparam int            CW      = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  state_t          state;
  state_t          state_next;
  logic [1:0]      mode_q;
  logic [DBIT-1:0] hold;
  logic [CW-1:0]   count;
  logic [CW-1:0]   idx;
  logic [DBIT-1:0] xdata;
  logic [DBIT-1:0] buf_rdata;
  logic            buf_we;
  logic            is_eol;
  logic            rd_int;
  logic            wr_int;
  logic [DBIT-1:0] wd_int;

  // End-of-line detection looks at the raw character, before any case folding
  assign is_eol = (bus.r_data == EOL);

  if (DBIT == 8) begin : g_upper
    assign xdata = mode_q[MODE_UPPER] ? to_upper(bus.r_data) : bus.r_data;
  end else begin : g_plain
    assign xdata = bus.r_data;
  end

  uart_line_buf #(
    .DBIT  (DBIT),
    .DEPTH (DEPTH)
  ) u_line_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (count[AW-1:0]),
    .wdata (xdata),
    .raddr (idx[AW-1:0]),
    .rdata (buf_rdata)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and output decode; strobes are combinational so a reset
  // removes them in the same instant
  always_comb begin
    state_next = state;
    rd_int     = 1'b0;
    wr_int     = 1'b0;
    wd_int     = '0;
    buf_we     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!bus.rx_empty) state_next = ST_FETCH;
      end
      ST_FETCH: begin
        rd_int = 1'b1;
        if (!mode_q[MODE_LINE]) begin
          state_next = ST_SEND;
        end else if (is_eol) begin
          state_next = ST_REPLAY;
        end else begin
          buf_we     = (count < DEPTH_C);
          state_next = ST_IDLE;
        end
      end
      ST_SEND: begin
        wd_int = hold;
        wr_int = ~bus.tx_full;
        if (!bus.tx_full) state_next = ST_IDLE;
      end
      ST_REPLAY: begin
        wr_int = ~bus.tx_full;
        if (idx < count) begin
          wd_int = buf_rdata;
        end else begin
          // Buffered characters done; the held EOL closes the burst
          wd_int = hold;
          if (!bus.tx_full) state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Datapath: mode latch, held character, line occupancy, replay index, drops
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q   <= '0;
      hold     <= '0;
      count    <= '0;
      idx      <= '0;
      drop_cnt <= '0;
    end else begin
      if (state == ST_IDLE) begin
        mode_q <= mode;
        // Leaving line mode abandons a partial line; not counted as drops
        if (mode_q[MODE_LINE] && !mode[MODE_LINE] && (count != '0)) begin
          count <= '0;
        end
      end
      if (state == ST_FETCH) begin
        hold <= xdata;
        if (mode_q[MODE_LINE]) begin
          if (is_eol) begin
            idx <= '0;
          end else if (count < DEPTH_C) begin
            count <= count + CW'(1);
          end else if (drop_cnt != '1) begin
            drop_cnt <= drop_cnt + CNT_W'(1);
          end
        end
      end
      if (state == ST_REPLAY && !bus.tx_full) begin
        if (idx < count) begin
          idx <= idx + CW'(1);
        end else begin
          idx   <= '0;
          count <= '0;
        end
      end
    end
  end

  assign bus.rd_uart = rd_int;
  assign bus.wr_uart = wr_int;
  assign bus.w_data  = wd_int;
  assign busy        = (state != ST_IDLE) || (count != '0);

endmodule
`default_nettype wire

// File: tb/tb_uart_echo_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_echo_engine
// Purpose  : Directed self-checking bench for uart_echo_engine (DEPTH=4).
//            An RX FIFO model feeds the engine; a negedge monitor logs every
//            pop and push with its cycle number.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_echo_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] mode = 2'b00;
  logic       busy;
  logic [7:0] drop_cnt;

  uart_echo_engine_if #(.DBIT(8)) bus();

  uart_echo_engine #(
    .DBIT  (8),
    .DEPTH (4),
    .EOL   (8'h0D),
    .CNT_W (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mode     (mode),
    .bus      (bus),
    .busy     (busy),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  int checks  = 0;
  int errors  = 0;
  int cyc     = 0;
  int inv_err = 0;

  logic [7:0] rxq[$];
  logic [7:0] txq[$];
  int         rd_cyc[$];
  int         wr_cyc[$];
  bit         pop_pending = 1'b0;

  task automatic rx_drive();
    bus.rx_empty = (rxq.size() == 0);
    bus.r_data   = (rxq.size() != 0) ? rxq[0] : 8'h00;
  endtask

  // Monitor: outputs are stable mid-cycle
  always @(negedge clk) begin
    cyc++;
    if (bus.rd_uart === 1'b1) begin
      rd_cyc.push_back(cyc);
      pop_pending = 1'b1;
      if (bus.rx_empty) inv_err++;
    end
    if (bus.wr_uart === 1'b1) begin
      txq.push_back(bus.w_data);
      wr_cyc.push_back(cyc);
    end
    if (bus.rd_uart === 1'b1 && bus.wr_uart === 1'b1) inv_err++;
  end

  // RX FIFO model: pop takes effect just after the edge that consumed it
  always @(posedge clk) begin
    #1;
    if (pop_pending) begin
      pop_pending = 1'b0;
      if (rxq.size() != 0) void'(rxq.pop_front());
      rx_drive();
    end
  end

  function automatic logic [7:0] txd(input int i);
    return (i < txq.size()) ? txq[i] : 8'hxx;
  endfunction

  function automatic int wcy(input int i);
    return (i < wr_cyc.size()) ? wr_cyc[i] : -1;
  endfunction

  function automatic int rcy(input int i);
    return (i < rd_cyc.size()) ? rd_cyc[i] : -100;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [7:0] c);
    rxq.push_back(c);
    rx_drive();
  endtask

  task automatic clear_logs();
    txq.delete();
    rd_cyc.delete();
    wr_cyc.delete();
  endtask

  task automatic wait_tx(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step(1);
      if (txq.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bus.tx_full = 1'b0;
    rx_drive();
    #3 rst = 1'b0;
    #1;
    checks++; if (bus.rd_uart !== 1'b0) begin errors++; $display("FAIL reset_rd got %b want 0", bus.rd_uart); end
    checks++; if (bus.wr_uart !== 1'b0) begin errors++; $display("FAIL reset_wr got %b want 0", bus.wr_uart); end
    checks++; if (bus.w_data !== 8'h00) begin errors++; $display("FAIL reset_wdata got %h want 00", bus.w_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (drop_cnt !== 8'h00) begin errors++; $display("FAIL reset_drop got %h want 00", drop_cnt); end
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    step(1);
  endtask

  task automatic test_echo();
    bit ok;
    clear_logs();
    mode = 2'b00;
    step(1);
    push(8'h41);
    wait_tx(1, 20, ok);
    step(3);
    checks++; if (!ok) begin errors++; $display("FAIL echo_timeout got %0d writes want 1", txq.size()); end
    checks++; if (rd_cyc.size() != 1) begin errors++; $display("FAIL echo_rd_count got %0d want 1", rd_cyc.size()); end
    checks++; if (txq.size() != 1) begin errors++; $display("FAIL echo_wr_count got %0d want 1", txq.size()); end
    checks++; if (txd(0) !== 8'h41) begin errors++; $display("FAIL echo_data got %h want 41", txd(0)); end
    checks++; if (wcy(0) != rcy(0) + 1) begin errors++; $display("FAIL echo_latency got wr@%0d want %0d", wcy(0), rcy(0) + 1); end
    checks++; if (drop_cnt !== 8'h00) begin errors++; $display("FAIL echo_drop got %h want 00", drop_cnt); end
  endtask

  task automatic test_uppercase();
    bit ok;
    logic [7:0] exp [3];
    exp[0] = 8'h41; exp[1] = 8'h5A; exp[2] = 8'h7B;
    clear_logs();
    mode = 2'b01;
    step(1);
    push(8'h61); push(8'h5A); push(8'h7B);
    wait_tx(3, 40, ok);
    step(3);
    checks++; if (!ok || txq.size() != 3) begin errors++; $display("FAIL upper_count got %0d want 3", txq.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (txd(i) !== exp[i]) begin errors++; $display("FAIL upper_data[%0d] got %h want %h", i, txd(i), exp[i]); end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    clear_logs();
    mode = 2'b00;
    bus.tx_full = 1'b1;
    step(1);
    push(8'h33); push(8'h34);
    step(12);
    checks++; if (txq.size() != 0) begin errors++; $display("FAIL bp_no_write got %0d writes want 0", txq.size()); end
    checks++; if (rd_cyc.size() != 1) begin errors++; $display("FAIL bp_no_read got %0d pops want 1", rd_cyc.size()); end
    checks++; if (bus.w_data !== 8'h33) begin errors++; $display("FAIL bp_wdata_held got %h want 33", bus.w_data); end
    bus.tx_full = 1'b0;
    wait_tx(2, 20, ok);
    step(3);
    checks++; if (!ok || txq.size() != 2) begin errors++; $display("FAIL bp_release_count got %0d want 2", txq.size()); end
    checks++; if (txd(0) !== 8'h33) begin errors++; $display("FAIL bp_first got %h want 33", txd(0)); end
    checks++; if (txd(1) !== 8'h34) begin errors++; $display("FAIL bp_second got %h want 34", txd(1)); end
  endtask

  task automatic test_line();
    bit ok;
    logic [7:0] exp [3];
    exp[0] = 8'h48; exp[1] = 8'h49; exp[2] = 8'h0D;
    clear_logs();
    mode = 2'b10;
    step(1);
    push(8'h48); push(8'h49);
    step(8);
    checks++; if (txq.size() != 0) begin errors++; $display("FAIL line_hold got %0d writes want 0", txq.size()); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL line_busy_pending got %b want 1", busy); end
    push(8'h0D);
    wait_tx(3, 40, ok);
    step(3);
    checks++; if (!ok || txq.size() != 3) begin errors++; $display("FAIL line_count got %0d want 3", txq.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (txd(i) !== exp[i]) begin errors++; $display("FAIL line_data[%0d] got %h want %h", i, txd(i), exp[i]); end
    end
    checks++; if (wcy(0) <= rcy(2)) begin errors++; $display("FAIL line_order got wr@%0d want after %0d", wcy(0), rcy(2)); end
    checks++; if (wcy(1) != wcy(0) + 1 || wcy(2) != wcy(0) + 2) begin errors++; $display("FAIL line_b2b got %0d,%0d,%0d want consecutive", wcy(0), wcy(1), wcy(2)); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL line_busy_end got %b want 0", busy); end
  endtask

  task automatic test_overflow();
    bit ok;
    logic [7:0] exp [5];
    exp[0] = 8'h41; exp[1] = 8'h42; exp[2] = 8'h43; exp[3] = 8'h44; exp[4] = 8'h0D;
    clear_logs();
    mode = 2'b11;
    step(1);
    for (int i = 0; i < 6; i++) push(8'h61 + 8'(i));
    push(8'h0D);
    wait_tx(5, 100, ok);
    step(4);
    checks++; if (!ok || txq.size() != 5) begin errors++; $display("FAIL ovf_count got %0d want 5", txq.size()); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (txd(i) !== exp[i]) begin errors++; $display("FAIL ovf_data[%0d] got %h want %h", i, txd(i), exp[i]); end
    end
    checks++; if (drop_cnt !== 8'd2) begin errors++; $display("FAIL ovf_drop got %0d want 2", drop_cnt); end
  endtask

  task automatic test_reset_replay();
    bit ok;
    clear_logs();
    mode = 2'b10;
    step(1);
    push(8'h31); push(8'h32); push(8'h0D);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      #1;
      if (txq.size() >= 1) begin
        ok = 1'b1;
        break;
      end
    end
    rst = 1'b0;
    #1;
    checks++; if (!ok) begin errors++; $display("FAIL rr_timeout got %0d writes want 1", txq.size()); end
    checks++; if (bus.wr_uart !== 1'b0) begin errors++; $display("FAIL rr_wr got %b want 0", bus.wr_uart); end
    checks++; if (bus.w_data !== 8'h00) begin errors++; $display("FAIL rr_wdata got %h want 00", bus.w_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_busy got %b want 0", busy); end
    checks++; if (drop_cnt !== 8'h00) begin errors++; $display("FAIL rr_drop got %h want 00", drop_cnt); end
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    step(1);
    checks++; if (txq.size() != 1 || txd(0) !== 8'h31) begin errors++; $display("FAIL rr_partial got %0d writes first %h want 1 write 31", txq.size(), txd(0)); end
    clear_logs();
    push(8'h58); push(8'h0D);
    wait_tx(2, 40, ok);
    step(8);
    checks++; if (!ok || txq.size() != 2) begin errors++; $display("FAIL rr_next_count got %0d want 2", txq.size()); end
    checks++; if (txd(0) !== 8'h58) begin errors++; $display("FAIL rr_next_0 got %h want 58", txd(0)); end
    checks++; if (txd(1) !== 8'h0D) begin errors++; $display("FAIL rr_next_1 got %h want 0D", txd(1)); end
  endtask

  initial begin
    bus.tx_full  = 1'b0;
    bus.rx_empty = 1'b1;
    bus.r_data   = 8'h00;
    test_reset();
    test_echo();
    test_uppercase();
    test_backpressure();
    test_line();
    test_overflow();
    test_reset_replay();
    checks++; if (inv_err != 0) begin errors++; $display("FAIL invariants got %0d violations want 0", inv_err); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
